// File: rtl/tsv_link_pkg.sv
// tsv_link_pkg: constants and helpers shared by both ends of the inter-die
// TSV data link (tsv_link_tx on the driving die, tsv_link_rx on the receiver).
//   TSV_DATA_W      payload width, one TSV per bit
//   TSV_INIT_CREDIT credits the transmitter holds after reset (= rx FIFO depth)
//   calc_parity     even-parity bit for a payload word
package tsv_link_pkg;

   localparam int unsigned TSV_DATA_W      = 8;
   localparam int unsigned TSV_INIT_CREDIT = 4;

   // A good word satisfies calc_parity(data) == parity bit.
   function automatic logic calc_parity(input logic [TSV_DATA_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/tsv_rx_fifo.sv
// tsv_rx_fifo: DEPTH x DATA_W register FIFO for the TSV receive path.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (caller guarantees !full || pop)
//   push_data   word to write
//   pop         drop the head entry
//   full/empty  occupancy flags
//   head        registered head entry (valid when !empty)
module tsv_rx_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   // Extra MSB on each pointer separates full from empty; wraps mod 2*DEPTH.
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // With full && pop the write slot is the one being read out this
         // cycle, so overwriting it at the edge is safe.
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      head  = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/tsv_link_rx.sv
// tsv_link_rx: receive endpoint of the inter-die TSV link. Captures the TSV
// bundle, checks even parity, buffers good words and hands them to local
// logic over valid/ready. Each local pop returns one credit over tsv_credit.
//   clk, rst_n          link clock, asynchronous active-low reset
//   tsv_valid/data/parity  raw TSV inputs (registered with no logic in front)
//   tsv_credit          one-cycle pulse, cycle after each pop
//   out_valid/out_data/out_ready  local consumer handshake
//   err_cnt             saturating count of parity-failed words
//   ovf                 sticky: good word dropped because the FIFO was full
//   err_clr             synchronous clear of err_cnt and ovf (wins over update)
module tsv_link_rx
   import tsv_link_pkg::*;
#(
   parameter int unsigned DATA_W = TSV_DATA_W,
   parameter int unsigned DEPTH  = TSV_INIT_CREDIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tsv_valid,
   input  logic [DATA_W-1:0] tsv_data,
   input  logic              tsv_parity,
   output logic              tsv_credit,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [7:0]        err_cnt,
   output logic              ovf,
   input  logic              err_clr
);

   logic              cap_valid;
   logic [DATA_W-1:0] cap_data;
   logic              cap_parity;
   logic              par_ok;
   logic              pop;
   logic              push;
   logic              drop_full;
   logic              err_inc;
   logic              full;
   logic              empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid  <= 1'b0;
         cap_data   <= '0;
         cap_parity <= 1'b0;
      end else begin
         cap_valid  <= tsv_valid;
         cap_data   <= tsv_data;
         cap_parity <= tsv_parity;
      end
   end

   always_comb begin
      par_ok    = (calc_parity(cap_data) == cap_parity);
      out_valid = !empty;
      pop       = out_valid && out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push      = cap_valid && par_ok && (!full || pop);
      drop_full = cap_valid && par_ok && full && !pop;
      err_inc   = cap_valid && !par_ok && (err_cnt != 8'hFF);
   end

   tsv_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (cap_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt    <= '0;
         ovf        <= 1'b0;
         tsv_credit <= 1'b0;
      end else begin
         tsv_credit <= pop;
         if (err_clr) begin
            err_cnt <= '0;
            ovf     <= 1'b0;
         end else begin
            if (err_inc)   err_cnt <= err_cnt + 8'd1;
            if (drop_full) ovf     <= 1'b1;
         end
      end
   end

endmodule
